// File: rtl/music_pkg.sv
// Shared types and constants for the beeper music path.
// State encoding and note-code conventions.
package music_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int NOTE_W    = 5;
   localparam int REST_CODE = 0;
   localparam int END_CODE  = 31;
   localparam int CLK_FREQ  = 50_000_000;

endpackage

// File: rtl/music_seq_ctrl_beat_timer.sv
// Beat position counter for the music sequencer.
// Counts only while run, clears on clr, otherwise holds.
module beat_timer #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic cap,
   output logic tc,
   output logic win_nxt
);

   localparam int CW = $clog2(BEAT_CYCLES);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_d;
   logic          at_end;

   assign at_end = (cnt == CW'(BEAT_CYCLES - 1));
   assign cap    = run & (cnt == CW'(1));
   assign tc     = run & at_end;

   // next count: clear wins, then advance with wrap, else hold
   always_comb begin
      cnt_d = cnt;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = at_end ? '0 : cnt + 1'b1;
      end
   end

   // next count lies inside the audible part of the beat
   assign win_nxt = (32'(cnt_d) >= 32'd2) &&
                    (32'(cnt_d) < 32'(BEAT_CYCLES - GAP_CYCLES));

   // count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_d;
      end
   end

endmodule

// File: rtl/music_seq_ctrl.sv
// Playback sequencer: buttons to song select, beat address
// and gated note code for the beeper frequency divider.
module music_seq_ctrl #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 500_000,
   parameter int NUM_SONGS   = 4,
   parameter int ADDR_W      = 6,
   parameter int NOTE_W      = music_pkg::NOTE_W,
   parameter int END_CODE    = music_pkg::END_CODE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         btn_play,
   input  logic                         btn_stop,
   input  logic                         btn_next,
   input  logic                         btn_prev,
   input  logic [NOTE_W-1:0]            note_in,
   output logic [$clog2(NUM_SONGS)-1:0] song_sel,
   output logic [ADDR_W-1:0]            beat_addr,
   output logic [NOTE_W-1:0]            music,
   output logic                         playing,
   output logic                         beat_tick
);

   import music_pkg::*;

   localparam int SW = $clog2(NUM_SONGS);
   localparam logic [SW-1:0] SONG_LAST = SW'(NUM_SONGS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t state, state_d;

   logic [NOTE_W-1:0] cur_note, cur_d, music_d;
   logic [SW-1:0]     song_d, song_inc, song_dec;
   logic [ADDR_W-1:0] addr_d;
   logic go_next, go_prev, nav, run;
   logic cap, tc, win_nxt;
   logic end_cap, wrap, eos, clr, tick_d;

   // next and prev cancel each other; stop overrides both
   assign go_next = btn_next & ~btn_prev & ~btn_stop;
   assign go_prev = btn_prev & ~btn_next & ~btn_stop;
   assign nav     = go_next | go_prev;

   // beat time only advances on undisturbed PLAY cycles
   assign run = (state == ST_PLAY) & ~btn_stop & ~nav & ~btn_play;

   assign end_cap = cap & (note_in == NOTE_W'(END_CODE));
   assign wrap    = tc & (beat_addr == ADDR_LAST);
   assign eos     = end_cap | wrap;
   assign clr     = btn_stop | nav | eos;

   assign song_inc = (song_sel == SONG_LAST) ? '0 : song_sel + 1'b1;
   assign song_dec = (song_sel == '0) ? SONG_LAST : song_sel - 1'b1;

   beat_timer #(
      .BEAT_CYCLES (BEAT_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .clr     (clr),
      .cap     (cap),
      .tc      (tc),
      .win_nxt (win_nxt)
   );

   // state transitions, song/address update and note gating
   always_comb begin
      state_d = state;
      if (btn_stop) begin
         state_d = ST_STOP;
      end else if (btn_play) begin
         state_d = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
      end

      song_d = song_sel;
      if (go_next | eos) begin
         song_d = song_inc;
      end else if (go_prev) begin
         song_d = song_dec;
      end

      addr_d = beat_addr;
      if (clr) begin
         addr_d = '0;
      end else if (tc) begin
         addr_d = beat_addr + 1'b1;
      end

      cur_d = cur_note;
      if (cap & ~end_cap) begin
         cur_d = note_in;
      end

      tick_d  = tc & ~wrap;
      music_d = '0;
      if ((state_d == ST_PLAY) && win_nxt) begin
         music_d = cur_d;
      end
   end

   // registered state and outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_STOP;
         song_sel  <= '0;
         beat_addr <= '0;
         cur_note  <= '0;
         music     <= '0;
         playing   <= 1'b0;
         beat_tick <= 1'b0;
      end else begin
         state     <= state_d;
         song_sel  <= song_d;
         beat_addr <= addr_d;
         cur_note  <= cur_d;
         music     <= music_d;
         playing   <= (state_d == ST_PLAY);
         beat_tick <= tick_d;
      end
   end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Bench for music_seq_ctrl: directed scenarios plus random
// button traffic against a cycle-level behavioural model.
module tb_music_seq_ctrl;

   localparam int BC = 10;
   localparam int GC = 2;
   localparam int NS = 4;
   localparam int AW = 3;
   localparam int NW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_play = 1'b0;
   logic btn_stop = 1'b0;
   logic btn_next = 1'b0;
   logic btn_prev = 1'b0;
   logic [NW-1:0] note_in = '0;
   logic [1:0]    song_sel;
   logic [AW-1:0] beat_addr;
   logic [NW-1:0] music;
   logic playing;
   logic beat_tick;

   int n_cmp = 0;
   int n_err = 0;

   // model: mode 0=stopped 1=playing 2=paused
   int m_mode, m_song, m_addr, m_pos, m_cur;
   int m_music, m_tick;

   always #5 clk = ~clk;

   music_seq_ctrl #(
      .BEAT_CYCLES (BC),
      .GAP_CYCLES  (GC),
      .NUM_SONGS   (NS),
      .ADDR_W      (AW),
      .NOTE_W      (NW),
      .END_CODE    (31)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_play  (btn_play),
      .btn_stop  (btn_stop),
      .btn_next  (btn_next),
      .btn_prev  (btn_prev),
      .note_in   (note_in),
      .song_sel  (song_sel),
      .beat_addr (beat_addr),
      .music     (music),
      .playing   (playing),
      .beat_tick (beat_tick)
   );

   function automatic int rom(input int s, input int a);
      if (s == 1 && a == 2) return 31;
      return (s * 8 + a + 1) % 32;
   endfunction

   // song ROM with one cycle registered read latency
   always @(posedge clk) begin
      note_in <= NW'(rom(int'(song_sel), int'(beat_addr)));
   end

   task automatic chk(input string tag, input int got,
                      input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_song = 0; m_addr = 0;
      m_pos = 0; m_cur = 0; m_music = 0; m_tick = 0;
   endtask

   task automatic next_song();
      m_song = (m_song + 1) % NS;
      m_addr = 0;
      m_pos  = 0;
   endtask

   // one clock edge of the reference behaviour
   task automatic model_edge(input bit p, input bit s,
                             input bit n, input bit v);
      bit fwd, back, adv;
      int nt;
      m_tick = 0;
      fwd  = n && !v;
      back = v && !n;
      if (s) begin
         m_mode = 0; m_addr = 0; m_pos = 0;
      end else begin
         adv = (m_mode == 1) && !p && !fwd && !back;
         if (fwd) next_song();
         if (back) begin
            m_song = (m_song + NS - 1) % NS;
            m_addr = 0;
            m_pos  = 0;
         end
         if (p) m_mode = (m_mode == 1) ? 2 : 1;
         if (adv) begin
            if (m_pos == 1) begin
               nt = rom(m_song, m_addr);
               if (nt == 31) next_song();
               else begin
                  m_cur = nt;
                  m_pos = 2;
               end
            end else if (m_pos == BC - 1) begin
               if (m_addr == (1 << AW) - 1) next_song();
               else begin
                  m_pos = 0;
                  m_addr++;
                  m_tick = 1;
               end
            end else begin
               m_pos++;
            end
         end
      end
      m_music = (m_mode == 1 && m_pos >= 2 && m_pos < BC - GC)
                ? m_cur : 0;
   endtask

   task automatic check_all();
      chk("song_sel", int'(song_sel), m_song);
      chk("beat_addr", int'(beat_addr), m_addr);
      chk("music", int'(music), m_music);
      chk("playing", int'(playing), int'(m_mode == 1));
      chk("beat_tick", int'(beat_tick), m_tick);
   endtask

   task automatic cycle(input bit p, input bit s,
                        input bit n, input bit v);
      @(negedge clk);
      btn_play = p; btn_stop = s;
      btn_next = n; btn_prev = v;
      @(posedge clk);
      model_edge(p, s, n, v);
      #1;
      check_all();
      btn_play = 0; btn_stop = 0;
      btn_next = 0; btn_prev = 0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(0, 0, 0, 0);
   endtask

   initial begin
      int r;
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      rst = 1'b1;

      // first notes and beat advance
      cycle(1, 0, 0, 0);
      chk("play_starts", int'(playing), 1);
      idle(5);
      chk("first_note", int'(music), 1);
      idle(5);
      chk("first_tick", int'(beat_tick), 1);
      chk("first_tick_addr", int'(beat_addr), 1);
      idle(5);
      chk("second_note", int'(music), 2);

      // pause mid-beat and resume
      idle(20);
      cycle(1, 0, 0, 0);
      idle(25);
      chk("paused_addr", int'(beat_addr), 3);
      chk("paused_music", int'(music), 0);
      cycle(1, 0, 0, 0);
      chk("resume_music", int'(music), 4);
      idle(4);
      cycle(0, 0, 0, 0);
      chk("resume_tick", int'(beat_tick), 1);

      // song end by address wrap, then by end code
      cycle(0, 1, 0, 0);
      cycle(1, 0, 0, 0);
      idle(80);
      chk("wrap_song", int'(song_sel), 1);
      chk("wrap_addr", int'(beat_addr), 0);
      chk("wrap_playing", int'(playing), 1);
      idle(25);
      chk("endcode_song", int'(song_sel), 2);
      chk("endcode_addr", int'(beat_addr), 0);

      // song navigation while stopped
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 1);
      chk("prev_wrap", int'(song_sel), 3);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      chk("next_twice", int'(song_sel), 1);
      cycle(0, 0, 1, 1);
      chk("next_prev_cancel", int'(song_sel), 1);

      // stop beats next
      cycle(1, 0, 0, 0);
      idle(14);
      cycle(0, 1, 1, 0);
      chk("stop_song", int'(song_sel), 1);
      chk("stop_addr", int'(beat_addr), 0);
      chk("stop_playing", int'(playing), 0);
      chk("stop_music", int'(music), 0);

      // asynchronous reset mid-note
      cycle(1, 0, 0, 0);
      idle(4);
      chk("pre_rst_music", int'(music), 9);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("arst_music", int'(music), 0);
      chk("arst_playing", int'(playing), 0);
      chk("arst_song", int'(song_sel), 0);
      chk("arst_addr", int'(beat_addr), 0);
      @(negedge clk);
      rst = 1'b1;
      idle(20);

      // random button traffic
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 199));
         cycle(r < 6 || r == 12, r == 6,
               r == 7 || r == 8 || r == 11 || r == 12,
               r == 9 || r == 10 || r == 11);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Playback sequencer for the beeper music path: turns user buttons (play/pause, stop, next, prev) into song selection, beat-timed song-ROM addressing and a gated note code for the frequency divider.
- Replaces the free-running beat counter. Sits between the debounced key inputs and the song ROM / freq_div / beep_drive chain.
- Adds an articulation gap at the end of each beat so that repeated notes are audibly separated.

Parameters:
- BEAT_CYCLES, 12_500_000, clk cycles per beat (250 ms at 50 MHz); must be >= 4.
- GAP_CYCLES, 500_000, trailing cycles of each beat forced to rest; must be < BEAT_CYCLES-2.
- NUM_SONGS, 4, number of songs selectable; must be >= 2.
- ADDR_W, 6, beat address width (max 2^ADDR_W beats per song).
- NOTE_W, 5, note code width; code 0 = rest.
- END_CODE, 31, note code marking end of song.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_play  in  1  single-cycle pulse; toggles play/pause, or starts playback from stop
- btn_stop  in  1  single-cycle pulse; stop and rewind
- btn_next  in  1  single-cycle pulse; next song
- btn_prev  in  1  single-cycle pulse; previous song
- note_in  in  NOTE_W  song ROM data; 1-cycle registered read latency from song_sel/beat_addr
- song_sel  out  $clog2(NUM_SONGS)  selected song to ROM
- beat_addr  out  ADDR_W  beat index to ROM
- music  out  NOTE_W  note code to freq_div (0 = silent)
- playing  out  1  high in PLAY state
- beat_tick  out  1  single-cycle pulse on each beat advance

Behaviour:
- Reset (rst low, asynchronous): state=STOP; song_sel=0, beat_addr=0, beat_cnt=0, music=0, playing=0, beat_tick=0.
- All outputs are registered.
- beat_cnt has width $clog2(BEAT_CYCLES). It counts 0..BEAT_CYCLES-1 only in PLAY, holds in PAUSE, and is 0 in STOP.
- FSM states: STOP, PLAY, PAUSE.
  - STOP + btn_play -> PLAY, starting at the current song_sel, beat 0.
  - PLAY + btn_play -> PAUSE.
  - PAUSE + btn_play -> PLAY, resuming at the held beat_cnt and beat_addr.
  - Any state + btn_stop -> STOP; beat_addr=0, beat_cnt=0, music=0. song_sel is kept.
- Button priority in the same cycle: stop > next/prev > play.
  - next and prev asserted together: both ignored.
  - next or prev together with play: the song change applies and the play transition also applies.
- Next/prev:
  - song_sel increments or decrements modulo NUM_SONGS (wraps 0 <-> NUM_SONGS-1).
  - beat_addr=0, beat_cnt=0, music=0. The FSM state is unchanged.
- Beat advance (PLAY and beat_cnt==BEAT_CYCLES-1):
  - beat_cnt=0, beat_addr+1, beat_tick=1 for one cycle.
  - If beat_addr==2^ADDR_W-1, end of song applies instead (see below).
- Note capture: when PLAY and beat_cnt==1, the sequencer samples note_in, which is valid for the current address given the 1-cycle ROM latency.
  - If note_in==END_CODE, end of song applies, and music stays 0.
  - Otherwise the note is latched into cur_note.
- End of song (auto-advance):
  - song_sel = next song (wrapping), beat_addr=0, beat_cnt=0, music=0; the FSM stays in PLAY.
  - No beat_tick is issued for this transition.
- music output:
  - In PLAY with 2 <= beat_cnt < BEAT_CYCLES-GAP_CYCLES: music=cur_note.
  - At beat_cnt 0..1 and throughout the gap window: music=0.
  - In PAUSE and STOP: music=0. PAUSE keeps cur_note, so resuming inside the note window re-sounds it.
- playing = (state==PLAY).
- Reset mid-beat: all registers clear immediately, with no partial-beat carry.

Decomposition:
- Shared package music_pkg:
  - state encoding (ST_STOP, ST_PLAY, ST_PAUSE)
  - NOTE_W, REST_CODE=0, END_CODE=31
  - CLK_FREQ=50_000_000
- One natural sub-module, beat_timer: beat_cnt with run/clear/hold controls; outputs capture strobe (cnt==1), gap flag and terminal-count pulse.
- The FSM, song/address logic and note gating stay in the top level.

Test Plan:
Bench parameters: BEAT_CYCLES=10, GAP_CYCLES=2, NUM_SONGS=4, ADDR_W=3. The ROM model returns note = {song, addr}+1, except song 1 addr 2 = 31.
1. Reset then btn_play -> playing=1 next cycle. music=1 during beat_cnt 2..7 and 0 at cnt 8,9. beat_tick at cycle 10 with beat_addr=1. music=2 in the next beat.
2. Play 3 beats, btn_play (pause) for 25 cycles, btn_play again -> beat_addr and beat_cnt frozen during pause, music=0. Timing resumes exactly where it stopped, with no extra beat_tick.
3. Song 0 plays to beat_addr=7 -> after that beat, song_sel=1 and beat_addr=0 while still playing. In song 1 at addr 2, the capture reads 31 -> song_sel=2, beat_addr=0, music never 31.
4. In STOP at song_sel=0, btn_prev -> song_sel=3. btn_next twice -> song_sel=1. next+prev in the same cycle -> song_sel unchanged.
5. Mid-beat in PLAY, btn_stop together with btn_next -> state=STOP, beat_addr=0, song_sel unchanged, music=0 next cycle.
6. Assert rst low asynchronously mid-note -> all outputs 0 without a clock edge. After release with no buttons pressed, the block stays in STOP with music=0.
